// File: rtl/ydiv.sv
// Sequential restoring divider: one shift-subtract step per clock, unsigned or
// two's-complement signed, quotient and remainder delivered together on done.
module ydiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_EXT = (WIDTH + 1)'(1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] part;     // partial remainder P; its shifted form is WIDTH+1 wide
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             sign_q;
  logic             sign_r;
  logic             dbz_pend;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             is_ovf;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    a_abs   = (ctrl && a[WIDTH-1]) ? (~a + ONE) : a;
    b_abs   = (ctrl && b[WIDTH-1]) ? (~b + ONE) : b;
    is_ovf  = ctrl && (a == MIN_NEG) && (b == '1);
    shifted = {part, quo[WIDTH-1]};
    diff    = shifted + ~{1'b0, dvs} + ONE_EXT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      part     <= '0;
      quo      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      dbz_pend <= 1'b0;
      q        <= '0;
      r        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            dbz      <= 1'b0;
            cnt      <= '0;
            dvs      <= b_abs;
            dbz_pend <= 1'b0;
            // Special cases preload the final result into quo/part with signs
            // cleared, so FIX passes them through unchanged.
            if (b == '0) begin
              quo      <= '1;
              part     <= a;
              sign_q   <= 1'b0;
              sign_r   <= 1'b0;
              dbz_pend <= 1'b1;
              state    <= FIX;
            end else if (is_ovf) begin
              quo    <= MIN_NEG;
              part   <= '0;
              sign_q <= 1'b0;
              sign_r <= 1'b0;
              state  <= FIX;
            end else begin
              quo    <= a_abs;
              part   <= '0;
              sign_q <= ctrl & (a[WIDTH-1] ^ b[WIDTH-1]);
              sign_r <= ctrl & a[WIDTH-1];
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (!diff[WIDTH]) begin
            part <= diff[WIDTH-1:0];
            quo  <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            part <= shifted[WIDTH-1:0];
            quo  <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          q     <= sign_q ? (~quo + ONE) : quo;
          r     <= sign_r ? (~part + ONE) : part;
          dbz   <= dbz_pend;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ydiv.md
# ydiv

Sequential 32-bit integer divider, the multi-cycle counterpart to the single-cycle add/subtract unit. It performs one restoring shift-subtract step per clock and supports both the unsigned form (RISC-V DIVU/REMU) and the signed form (DIV/REM). It sits beside the ALU in the execute stage and is driven through a start/busy/done handshake. Quotient and remainder are produced together.

## Interface
- WIDTH, 32, operand and result width; the iteration count equals WIDTH.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a division; sampled only while in IDLE
- ctrl  input  1  0 = unsigned, 1 = signed (two's complement); sampled with start
- a  input  WIDTH  dividend; sampled with start
- b  input  WIDTH  divisor; sampled with start
- q  output  WIDTH  quotient, registered
- r  output  WIDTH  remainder, registered
- busy  output  1  high from the cycle after start is accepted until done rises
- done  output  1  one-cycle pulse; q, r and dbz are valid from this cycle
- dbz  output  1  divide-by-zero flag, valid with done

## Operation
- Reset is synchronous and active-high, on clk. It applies in any state, including mid-division: state goes to IDLE and q, r, busy, done, dbz and all internal registers clear to 0.
- States and transitions:
  - IDLE: start=1 goes to RUN, or to FIX on a special case.
  - RUN: after WIDTH iterations, goes to FIX.
  - FIX: goes to IDLE.
- Accept, when start=1 in IDLE:
  - Latch ctrl.
  - Latch |a| and |b|. Absolute values are taken only when ctrl=1; when ctrl=0, a and b are used raw.
  - Record sign_q = a[msb]^b[msb] and sign_r = a[msb]; both are forced to 0 when ctrl=0.
  - Clear the partial remainder P (WIDTH+1 bits) and the iteration count.
- RUN iteration, one per cycle:
  - {P, Q} shifts left 1.
  - Compute D = P - {0, |b|} using a WIDTH+1-bit subtract (adder with inverted b and carry-in 1).
  - If D is non-negative, P = D and Q[0] = 1; otherwise P is unchanged and Q[0] = 0.
  - The count increments; after the WIDTH-th iteration the state goes to FIX.
- FIX:
  - q = sign_q ? -Q : Q.
  - r = sign_r ? -P[WIDTH-1:0] : P[WIDTH-1:0].
  - done = 1 for this cycle only.
- Special cases are detected at accept. They skip RUN and go straight to FIX with fixed results:
  - b = 0: q = all ones, r = a, dbz = 1. This holds for both signed and unsigned.
  - ctrl=1, a = 0x80000000, b = 0xFFFFFFFF (signed overflow): q = 0x80000000, r = 0, dbz = 0.
- Remainder sign follows the dividend. The quotient truncates toward zero.
- start while busy=1 is ignored; there is no queueing. Operand changes while busy have no effect.
- q, r and dbz hold their values after done until the next accepted start. Outputs are not cleared at accept; they update only in FIX.
- dbz is cleared at every accept.

## Timing
- Edge E0 is the edge at which start is sampled in IDLE.
- Normal case:
  - busy is high after E0 through E32.
  - Iterations occur at E1..E32.
  - FIX registers results at E33, so done is high during the cycle after E33.
  - Latency is WIDTH+1 = 33 edges from accept to results.
  - done and busy are low again after E34.
- Special case: FIX at E1, done high after E1 and low after E2. busy is high only during the cycle after E0.
- Back-to-back: start may be high in the same cycle as done. It is accepted at the next edge, since the state is IDLE after FIX. Maximum throughput is one division per 34 cycles.
- Reset during the same cycle as start: reset wins and the operation is not accepted.
- done is never high in two consecutive cycles.

## Test plan
- Unsigned: ctrl=0, a=100, b=7, start for one cycle -> done exactly 33 edges after accept, q=14, r=2, dbz=0; busy high for 33 cycles.
- Signed, all sign combinations with |a|=7, |b|=2:
  - 7/2 -> q=3, r=1
  - -7/2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1)
  - 7/-2 -> q=-3, r=1
  - -7/-2 -> q=3, r=-1
- Divide by zero: a=0x12345678, b=0, ctrl=0 or 1 -> done 1 edge after accept, q=0xFFFFFFFF, r=0x12345678, dbz=1.
- Signed overflow: ctrl=1, a=0x80000000, b=0xFFFFFFFF -> q=0x80000000, r=0, 1-edge latency. The same operands with ctrl=0 -> q=0, r=0x80000000 after 33 edges.
- Handshake:
  - start held high continuously with new operands on each done cycle -> one accept per 34 cycles; results match each operand set.
  - start pulses while busy -> ignored; the in-flight result is unchanged.
- Reset at iteration 15 of a=0xFFFFFFFF, b=3 -> next cycle idle with all outputs 0. A new start with a=0xFFFFFFFF, b=3 then gives q=0x55555555, r=0.
